// File: rtl/pulser_pkg.sv
// Shared definitions for the queued waveform pulser: default field widths,
// command field offsets, mode-bit positions and a command pack helper.
package pulser_pkg;

   localparam int D_AW      = 10;
   localparam int D_LW      = 12;
   localparam int D_NDEST   = 4;
   localparam int D_PW      = 14;
   localparam int D_FW      = 24;
   localparam int D_TSLICEL = 2;
   localparam int D_DEPTH   = 4;

   // bit positions inside the 2-bit mode field
   localparam int MODE_ZERO_BIT  = 0;
   localparam int MODE_PCONT_BIT = 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PLAY = 1'b1
   } play_state_t;

   typedef enum int {
      FLD_FREQ,
      FLD_PHASE,
      FLD_LEN,
      FLD_MIDX,
      FLD_MODE,
      FLD_DEST
   } field_e;

   function automatic int dest_width(input int ndest);
      return (ndest > 1) ? $clog2(ndest) : 1;
   endfunction

   function automatic int cmd_width(input int destw, input int aw, input int lw,
                                    input int pw, input int fw);
      return destw + 2 + aw + lw + pw + fw;
   endfunction

   // LSB of each command field; command is dest|mode|mindex|length|phase|freq
   function automatic int field_lsb(input field_e f, input int aw, input int lw,
                                    input int pw, input int fw);
      case (f)
         FLD_FREQ:  return 0;
         FLD_PHASE: return fw;
         FLD_LEN:   return fw + pw;
         FLD_MIDX:  return fw + pw + lw;
         FLD_MODE:  return fw + pw + lw + aw;
         default:   return fw + pw + lw + aw + 2;
      endcase
   endfunction

   localparam int D_DESTW = dest_width(D_NDEST);
   localparam int D_CW    = cmd_width(D_DESTW, D_AW, D_LW, D_PW, D_FW);

   // builds a command word at the default widths
   function automatic logic [D_CW-1:0] pack_cmd(input logic [D_DESTW-1:0] dest,
                                                input logic [1:0]         mode,
                                                input logic [D_AW-1:0]    mindex,
                                                input logic [D_LW-1:0]    length,
                                                input logic [D_PW-1:0]    phase,
                                                input logic [D_FW-1:0]    freq);
      return {dest, mode, mindex, length, phase, freq};
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead command FIFO: rdata always presents the head entry.
// Pushes into a full queue and pops from an empty one are ignored.
module cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int CW    = 64,
   localparam int LVW  = $clog2(DEPTH + 1)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           flush,
   input  logic           push,
   input  logic [CW-1:0]  wdata,
   input  logic           pop,
   output logic [CW-1:0]  rdata,
   output logic           full,
   output logic           empty,
   output logic [LVW-1:0] level
);

   localparam int PTRW = $clog2(DEPTH);

   logic [CW-1:0]   mem [DEPTH];
   logic [PTRW-1:0] wr_ptr;
   logic [PTRW-1:0] rd_ptr;
   logic [LVW-1:0]  count;
   logic            push_ok;
   logic            pop_ok;

   assign full    = (count == LVW'(DEPTH));
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rdata   = mem[rd_ptr];
   assign level   = count;

   // storage array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push_ok && !flush) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // pointers and occupancy; flush empties the queue
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTRW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + PTRW'(1);
         case ({push_ok, pop_ok})
            2'b10:   count <= count + LVW'(1);
            2'b01:   count <= count - LVW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/pulser_queued.sv
// Queued waveform pulser: accepts packed commands into a small FIFO and
// plays them back-to-back, driving waveform index, phase and channel select.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_IDLE | no pulse playing; loads the queue head when one is present
// ST_PLAY | pulse playing; on its last cycle loads the next head if any
module pulser_queued
   import pulser_pkg::*;
#(
   parameter int AW      = D_AW,
   parameter int LW      = D_LW,
   parameter int NDEST   = D_NDEST,
   parameter int PW      = D_PW,
   parameter int FW      = D_FW,
   parameter int TSLICEL = D_TSLICEL,
   parameter int DEPTH   = D_DEPTH,
   localparam int DESTW  = dest_width(NDEST),
   localparam int CW     = cmd_width(DESTW, AW, LW, PW, FW),
   localparam int LVW    = $clog2(DEPTH + 1)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [CW-1:0]        cmd,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 flush,
   output logic                 overflow,
   output logic                 done,
   output logic [LVW-1:0]       level,
   output logic                 active,
   output logic [NDEST-1:0]     qsel,
   output logic [AW-1:0]        mindex,
   output logic [16:0]          phase,
   output logic [16+TSLICEL:0]  ts_phstep,
   output logic                 zero
);

   // phase accumulator keeps only the bits below the time-slice field
   localparam int PAW       = FW - TSLICEL;
   localparam int FREQ_LSB  = field_lsb(FLD_FREQ,  AW, LW, PW, FW);
   localparam int PHASE_LSB = field_lsb(FLD_PHASE, AW, LW, PW, FW);
   localparam int LEN_LSB   = field_lsb(FLD_LEN,   AW, LW, PW, FW);
   localparam int MIDX_LSB  = field_lsb(FLD_MIDX,  AW, LW, PW, FW);
   localparam int MODE_LSB  = field_lsb(FLD_MODE,  AW, LW, PW, FW);
   localparam int DEST_LSB  = field_lsb(FLD_DEST,  AW, LW, PW, FW);

   play_state_t       state;
   logic [AW-1:0]     mindex_r;
   logic [LW-1:0]     length_r;
   logic [FW-1:0]     freq_r;
   logic [PAW-1:0]    phase_acc;
   logic [NDEST-1:0]  qsel_r;
   logic              zero_r;
   logic              done_r;

   logic [CW-1:0]     head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              push;
   logic              pop;

   logic [DESTW-1:0]  hd_dest;
   logic [1:0]        hd_mode;
   logic [AW-1:0]     hd_midx;
   logic [LW-1:0]     hd_len;
   logic [PW-1:0]     hd_phase;
   logic [FW-1:0]     hd_freq;
   logic [NDEST-1:0]  hd_qsel;
   logic [PAW-1:0]    step;

   assign cmd_ready = !fifo_full;
   assign push      = cmd_valid && !fifo_full && !flush;
   assign overflow  = cmd_valid && fifo_full && !flush;
   assign pop       = !fifo_empty && !flush &&
                      ((state == ST_IDLE) || (length_r == LW'(1)));

   cmd_fifo #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .push  (push),
      .wdata (cmd),
      .pop   (pop),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (level)
   );

   assign hd_dest  = head[DEST_LSB  +: DESTW];
   assign hd_mode  = head[MODE_LSB  +: 2];
   assign hd_midx  = head[MIDX_LSB  +: AW];
   assign hd_len   = head[LEN_LSB   +: LW];
   assign hd_phase = head[PHASE_LSB +: PW];
   assign hd_freq  = head[FREQ_LSB  +: FW];
   assign step     = freq_r[PAW-1:0];

   // one-hot channel select for the head command; out-of-range dest selects nothing
   always_comb begin
      hd_qsel = '0;
      if (int'(hd_dest) < NDEST) hd_qsel[hd_dest] = 1'b1;
   end

   // playback FSM with index, length and phase accumulators
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         mindex_r  <= '0;
         length_r  <= '0;
         freq_r    <= '0;
         phase_acc <= '0;
         qsel_r    <= '0;
         zero_r    <= 1'b0;
         done_r    <= 1'b0;
      end else if (flush) begin
         state  <= ST_IDLE;
         qsel_r <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         if (pop) begin
            if (hd_len == '0) begin
               // empty command is discarded; a pulse ending now still ends
               state  <= ST_IDLE;
               qsel_r <= '0;
            end else begin
               state    <= ST_PLAY;
               qsel_r   <= hd_qsel;
               mindex_r <= hd_midx;
               length_r <= hd_len;
               freq_r   <= hd_freq;
               zero_r   <= hd_mode[MODE_ZERO_BIT];
               done_r   <= (hd_len == LW'(1));
               if (!hd_mode[MODE_PCONT_BIT]) begin
                  phase_acc <= PAW'(hd_phase) << (PAW - PW);
               end else if (state == ST_PLAY) begin
                  // keep advancing across the boundary so the phase has no jump
                  phase_acc <= phase_acc + step;
               end
            end
         end else if (state == ST_PLAY) begin
            if (length_r == LW'(1)) begin
               state  <= ST_IDLE;
               qsel_r <= '0;
            end else begin
               mindex_r  <= mindex_r + AW'(1);
               length_r  <= length_r - LW'(1);
               phase_acc <= phase_acc + step;
               done_r    <= (length_r == LW'(2));
            end
         end
      end
   end

   assign active    = (state == ST_PLAY);
   assign done      = done_r;
   assign qsel      = qsel_r;
   assign mindex    = mindex_r;
   assign phase     = phase_acc[PAW-1 -: 17];
   assign ts_phstep = freq_r[FW-1 -: 17+TSLICEL];
   assign zero      = zero_r;

endmodule

// File: tb/tb_pulser_queued.sv
// Directed bench for pulser_queued at default parameters.
module tb_pulser_queued;
   import pulser_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [63:0] cmd;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        flush;
   logic        overflow;
   logic        done;
   logic [2:0]  level;
   logic        active;
   logic [3:0]  qsel;
   logic [9:0]  mindex;
   logic [16:0] phase;
   logic [18:0] ts_phstep;
   logic        zero;

   int total = 0;
   int bad   = 0;

   pulser_queued dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd       (cmd),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .flush     (flush),
      .overflow  (overflow),
      .done      (done),
      .level     (level),
      .active    (active),
      .qsel      (qsel),
      .mindex    (mindex),
      .phase     (phase),
      .ts_phstep (ts_phstep),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_cmd(input logic [63:0] c);
      cmd       = c;
      cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL reset_level got=%0d exp=0", level); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b exp=0", active); end
      total++; if (qsel !== 4'd0) begin bad++; $display("FAIL reset_qsel got=%h exp=0", qsel); end
      total++; if (mindex !== 10'd0) begin bad++; $display("FAIL reset_mindex got=%h exp=0", mindex); end
      total++; if (phase !== 17'd0) begin bad++; $display("FAIL reset_phase got=%h exp=0", phase); end
      total++; if (ts_phstep !== 19'd0) begin bad++; $display("FAIL reset_ts got=%h exp=0", ts_phstep); end
      total++; if ({done, overflow, zero} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {done, overflow, zero}); end
   endtask

   task automatic test_single();
      logic [9:0]  em [4] = '{10'h005, 10'h006, 10'h007, 10'h007};
      logic [16:0] ep [4] = '{17'h0800, 17'h1000, 17'h1800, 17'h1800};
      logic        ea [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
      logic        ed [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0]  eq [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b0000};
      push_cmd(pack_cmd(2'd2, 2'b00, 10'h005, 12'd3, 14'h100, 24'h010000));
      total++; if (level !== 3'd1) begin bad++; $display("FAIL single_level got=%0d exp=1", level); end
      total++; if (active !== 1'b0) begin bad++; $display("FAIL single_early got=%b exp=0", active); end
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (active !== ea[i]) begin bad++; $display("FAIL single_active[%0d] got=%b exp=%b", i, active, ea[i]); end
         total++; if (mindex !== em[i]) begin bad++; $display("FAIL single_mindex[%0d] got=%h exp=%h", i, mindex, em[i]); end
         total++; if (phase !== ep[i]) begin bad++; $display("FAIL single_phase[%0d] got=%h exp=%h", i, phase, ep[i]); end
         total++; if (done !== ed[i]) begin bad++; $display("FAIL single_done[%0d] got=%b exp=%b", i, done, ed[i]); end
         total++; if (qsel !== eq[i]) begin bad++; $display("FAIL single_qsel[%0d] got=%h exp=%h", i, qsel, eq[i]); end
      end
      total++; if (ts_phstep !== 19'h0800) begin bad++; $display("FAIL single_ts got=%h exp=800", ts_phstep); end
   endtask

   task automatic test_back_to_back();
      logic [9:0]  em [5] = '{10'h010, 10'h011, 10'h3FF, 10'h000, 10'h000};
      logic [16:0] ep [5] = '{17'h200, 17'h220, 17'h400, 17'h440, 17'h440};
      logic        ea [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      logic        ed [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      logic [3:0]  eq [5] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0000};
      logic        ez [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      push_cmd(pack_cmd(2'd0, 2'b00, 10'h010, 12'd2, 14'h040, 24'h000400));
      push_cmd(pack_cmd(2'd1, 2'b01, 10'h3FF, 12'd2, 14'h080, 24'h000800));
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         total++; if (active !== ea[i]) begin bad++; $display("FAIL b2b_active[%0d] got=%b exp=%b", i, active, ea[i]); end
         total++; if (mindex !== em[i]) begin bad++; $display("FAIL b2b_mindex[%0d] got=%h exp=%h", i, mindex, em[i]); end
         total++; if (phase !== ep[i]) begin bad++; $display("FAIL b2b_phase[%0d] got=%h exp=%h", i, phase, ep[i]); end
         total++; if (done !== ed[i]) begin bad++; $display("FAIL b2b_done[%0d] got=%b exp=%b", i, done, ed[i]); end
         total++; if (qsel !== eq[i]) begin bad++; $display("FAIL b2b_qsel[%0d] got=%h exp=%h", i, qsel, eq[i]); end
         total++; if (zero !== ez[i]) begin bad++; $display("FAIL b2b_zero[%0d] got=%b exp=%b", i, zero, ez[i]); end
      end
   endtask

   task automatic test_phase_cont();
      logic [16:0] ep [5] = '{17'h8000, 17'h8100, 17'h8200, 17'h8400, 17'h8400};
      logic [18:0] et [5] = '{19'h100, 19'h100, 19'h200, 19'h200, 19'h200};
      logic [9:0]  em [5] = '{10'h020, 10'h021, 10'h030, 10'h031, 10'h031};
      logic [3:0]  eq [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000};
      push_cmd(pack_cmd(2'd3, 2'b00, 10'h020, 12'd2, 14'h1000, 24'h002000));
      push_cmd(pack_cmd(2'd3, 2'b10, 10'h030, 12'd2, 14'h3FFF, 24'h004000));
      for (int i = 0; i < 5; i++) begin
         if (i > 0) step();
         total++; if (phase !== ep[i]) begin bad++; $display("FAIL pcont_phase[%0d] got=%h exp=%h", i, phase, ep[i]); end
         total++; if (ts_phstep !== et[i]) begin bad++; $display("FAIL pcont_ts[%0d] got=%h exp=%h", i, ts_phstep, et[i]); end
         total++; if (mindex !== em[i]) begin bad++; $display("FAIL pcont_mindex[%0d] got=%h exp=%h", i, mindex, em[i]); end
         total++; if (qsel !== eq[i]) begin bad++; $display("FAIL pcont_qsel[%0d] got=%h exp=%h", i, qsel, eq[i]); end
      end
   endtask

   task automatic test_fill();
      int n;
      push_cmd(pack_cmd(2'd0, 2'b00, 10'h100, 12'd20, 14'h0, 24'h0));
      step();
      for (int i = 0; i < 6; i++) begin
         cmd       = pack_cmd(2'd1, 2'b00, 10'h2A0 + 10'(i), 12'd1, 14'h0, 24'h0);
         cmd_valid = 1'b1;
         #1;
         total++; if (cmd_ready !== (i < 4)) begin bad++; $display("FAIL fill_ready[%0d] got=%b exp=%b", i, cmd_ready, (i < 4)); end
         total++; if (overflow !== (i >= 4)) begin bad++; $display("FAIL fill_ovf[%0d] got=%b exp=%b", i, overflow, (i >= 4)); end
         total++; if (level !== 3'((i < 4) ? i : 4)) begin bad++; $display("FAIL fill_level[%0d] got=%0d exp=%0d", i, level, (i < 4) ? i : 4); end
         step();
      end
      cmd_valid = 1'b0;
      #1;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL fill_ovf_idle got=%b exp=0", overflow); end
      total++; if (level !== 3'd4) begin bad++; $display("FAIL fill_level_full got=%0d exp=4", level); end
      n = 0;
      while (done !== 1'b1 && n < 40) begin step(); n++; end
      total++; if (n >= 40) begin bad++; $display("FAIL fill_wait got=timeout exp=done"); end
      total++; if (mindex !== 10'h113) begin bad++; $display("FAIL fill_last got=%h exp=113", mindex); end
      for (int k = 0; k < 4; k++) begin
         step();
         total++; if ({active, done} !== 2'b11) begin bad++; $display("FAIL fill_play[%0d] got=%b exp=11", k, {active, done}); end
         total++; if (mindex !== 10'h2A0 + 10'(k)) begin bad++; $display("FAIL fill_order[%0d] got=%h exp=%h", k, mindex, 10'h2A0 + 10'(k)); end
         total++; if (qsel !== 4'b0010) begin bad++; $display("FAIL fill_qsel[%0d] got=%h exp=2", k, qsel); end
      end
      step();
      total++; if (active !== 1'b0) begin bad++; $display("FAIL fill_end got=%b exp=0", active); end
   endtask

   task automatic test_flush();
      push_cmd(pack_cmd(2'd1, 2'b00, 10'h200, 12'd10, 14'h0, 24'h0));
      for (int k = 0; k < 4; k++) push_cmd(pack_cmd(2'd2, 2'b00, 10'h300 + 10'(k), 12'd5, 14'h0, 24'h0));
      total++; if (level !== 3'd4) begin bad++; $display("FAIL flush_pre_level got=%0d exp=4", level); end
      cmd       = pack_cmd(2'd0, 2'b00, 10'h3AA, 12'd3, 14'h0, 24'h0);
      cmd_valid = 1'b1;
      flush     = 1'b1;
      #1;
      total++; if (overflow !== 1'b0) begin bad++; $display("FAIL flush_ovf got=%b exp=0", overflow); end
      step();
      cmd_valid = 1'b0;
      flush     = 1'b0;
      total++; if (active !== 1'b0) begin bad++; $display("FAIL flush_active got=%b exp=0", active); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL flush_level got=%0d exp=0", level); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done got=%b exp=0", done); end
      total++; if (qsel !== 4'd0) begin bad++; $display("FAIL flush_qsel got=%h exp=0", qsel); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL flush_ready got=%b exp=1", cmd_ready); end
      total++; if (mindex !== 10'h203) begin bad++; $display("FAIL flush_hold got=%h exp=203", mindex); end
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if (active !== 1'b0) begin bad++; $display("FAIL flush_after[%0d] got=%b exp=0", k, active); end
      end
   endtask

   task automatic test_len0();
      push_cmd(pack_cmd(2'd2, 2'b01, 10'h055, 12'd0, 14'h123, 24'h001000));
      total++; if (level !== 3'd1) begin bad++; $display("FAIL len0_level got=%0d exp=1", level); end
      for (int k = 0; k < 3; k++) begin
         step();
         total++; if ({active, done, zero} !== 3'b000) begin bad++; $display("FAIL len0_flags[%0d] got=%b exp=000", k, {active, done, zero}); end
         total++; if (mindex !== 10'h203) begin bad++; $display("FAIL len0_mindex[%0d] got=%h exp=203", k, mindex); end
         total++; if (level !== 3'd0) begin bad++; $display("FAIL len0_pop[%0d] got=%0d exp=0", k, level); end
      end
      push_cmd(pack_cmd(2'd0, 2'b00, 10'h0A0, 12'd2, 14'h0, 24'h0));
      push_cmd(pack_cmd(2'd0, 2'b00, 10'h0F0, 12'd0, 14'h0, 24'h0));
      total++; if ({active, mindex} !== {1'b1, 10'h0A0}) begin bad++; $display("FAIL len0_tail0 got=%h exp=4a0", {active, mindex}); end
      step();
      total++; if ({active, done, mindex} !== {2'b11, 10'h0A1}) begin bad++; $display("FAIL len0_tail1 got=%h exp=ca1", {active, done, mindex}); end
      step();
      total++; if ({active, done, mindex} !== {2'b00, 10'h0A1}) begin bad++; $display("FAIL len0_tail2 got=%h exp=0a1", {active, done, mindex}); end
      total++; if (level !== 3'd0) begin bad++; $display("FAIL len0_tail_level got=%0d exp=0", level); end
   endtask

   task automatic test_reset_mid();
      push_cmd(pack_cmd(2'd3, 2'b01, 10'h3C0, 12'd10, 14'h200, 24'h001000));
      push_cmd(pack_cmd(2'd1, 2'b00, 10'h111, 12'd4, 14'h0, 24'h0));
      push_cmd(pack_cmd(2'd1, 2'b00, 10'h112, 12'd4, 14'h0, 24'h0));
      total++; if ({active, qsel} !== 5'b11000) begin bad++; $display("FAIL rmid_pre got=%b exp=11000", {active, qsel}); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if ({active, done, zero, overflow} !== 4'b0000) begin bad++; $display("FAIL rmid_flags got=%b exp=0000", {active, done, zero, overflow}); end
      total++; if ({qsel, mindex} !== 14'd0) begin bad++; $display("FAIL rmid_sel got=%h exp=0", {qsel, mindex}); end
      total++; if ({phase, ts_phstep} !== 36'd0) begin bad++; $display("FAIL rmid_phase got=%h exp=0", {phase, ts_phstep}); end
      total++; if ({cmd_ready, level} !== 4'b1000) begin bad++; $display("FAIL rmid_queue got=%b exp=1000", {cmd_ready, level}); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
      step();
      total++; if ({active, cmd_ready, level} !== 5'b01000) begin bad++; $display("FAIL rmid_after got=%b exp=01000", {active, cmd_ready, level}); end
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd       = '0;
      cmd_valid = 1'b0;
      flush     = 1'b0;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      test_single();
      test_back_to_back();
      test_phase_cont();
      test_fill();
      test_flush();
      test_len0();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pulser_queued.md
# pulser_queued

Parametrised successor to the single-command waveform pulser. It accepts packed pulse commands through a valid/ready handshake into a small command queue. It plays them back in order, back-to-back with no idle cycle, driving the waveform-memory index, phase and per-channel select. The block sits between the ISA command issue and the waveform playback/DAC datapath. It adds field-width generality, an N-channel destination, phase-continuous mode, flush, and overflow and done reporting.

## Interface
- AW, 10: waveform memory address width
- LW, 12: pulse length width (cycles)
- NDEST, 4: number of destination channels; DESTW = max(1, $clog2(NDEST))
- PW, 14: initial-phase field width
- FW, 24: frequency (phase-step) width; requires FW-TSLICEL ≥ PW and FW ≥ 17+TSLICEL
- TSLICEL, 2: log2 time-slices per clock
- DEPTH, 4: command queue depth (power of 2, ≥2)
- CW: derived command width, DESTW+2+AW+LW+PW+FW (64 at defaults)

Ports:
- clk  in  1  clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- cmd  in  CW  command, MSB→LSB: dest, mode[1:0] (bit1 phase_cont, bit0 zero), mindex, length, phase, freq
- cmd_valid  in  1  command offered
- cmd_ready  out  1  queue not full
- flush  in  1  synchronous abort: empty queue, end current pulse
- overflow  out  1  one-cycle pulse: cmd_valid while !cmd_ready (command dropped)
- done  out  1  one-cycle pulse on the last active cycle of each pulse
- level  out  $clog2(DEPTH+1)  queued command count
- active  out  1  pulse playing
- qsel  out  NDEST  one-hot destination, all zero when inactive
- mindex  out  AW  waveform memory index
- phase  out  17  phase_acc[FW-TSLICEL-1 -: 17]
- ts_phstep  out  17+TSLICEL  freq_r[FW-1 -: 17+TSLICEL]
- zero  out  1  zero flag of current/last pulse

## Operation
- Handshake: a command is written when cmd_valid & cmd_ready & !flush. cmd_ready = !full. A push is not allowed on the cycle a full queue pops.
- Playback FSM has two states, IDLE and PLAY.
- Load happens when the queue is non-empty and (IDLE, or PLAY with length_r==1). It pops the head and loads:
  - dest_r, mindex_r, length_r and freq_r from the command fields;
  - zero_r from mode[0];
  - phase_acc = {phase, (FW-TSLICEL-PW) zeros}, unless mode[1] is set. With mode[1], phase_acc continues accumulating with the new freq_r and the phase field is ignored.
- PLAY per cycle: mindex_r+1 (wraps modulo 2^AW), length_r−1, phase_acc += freq_r truncated to FW-TSLICEL bits (top TSLICEL bits of freq unused, wraps).
- PLAY with length_r==1 and queue empty → IDLE.
- Length-0 command: popped and discarded without entering PLAY. No done pulse, outputs unchanged.
- dest ≥ NDEST: qsel all zero while playing; the pulse still runs and raises done.
- flush: next cycle the state is IDLE, the queue is empty and done is not asserted. flush beats a simultaneous push and pop and does not raise overflow.
- Inactive outputs: qsel=0, active=0. mindex, phase, ts_phstep and zero hold their last values.

## Timing
- Reset (async assert, sync-safe deassert): every register is 0, the queue is empty, the FSM is in IDLE. Outputs are cmd_ready=1 and level=0, with all other outputs 0.
- Latency: accept at cycle N, so level increments at N+1. With the block idle, outputs are valid at N+2 (active=1, mindex=cmd.mindex, phase from cmd.phase).
- A pulse of length L is active for exactly L cycles. done is high on the L-th cycle.
- Back-to-back: the next queued pulse's first cycle immediately follows the previous pulse's last cycle. active stays 1.
- Reset mid-pulse: outputs clear immediately and queued commands are lost.

## Structure
- Package pulser_pkg holds the field-offset localparams computed from the parameters, mode-bit constants and a pack function for benches/ISA.
- Sub-module cmd_fifo: synchronous show-ahead FIFO with parameters DEPTH and CW, and outputs full, empty and level. pulser_queued holds the FSM and accumulators.

## Test plan
- Single pulse: mindex=5, length=3, phase=0x100, freq=0x10000, dest=2 → from N+2, three cycles with qsel=0b0100 and mindex 5,6,7, done on the 3rd cycle, then active=0.
- Back-to-back: two length-2 commands on consecutive cycles → active high 4 contiguous cycles, 2nd pulse reloads phase, done on cycles 2 and 4.
- Phase-continuous: second command with mode[1]=1, freq doubled → phase continues from end of first pulse with no reset, step doubles.
- Fill queue: DEPTH+2 commands during a long pulse → cmd_ready=0 at level=DEPTH, overflow pulses for rejected ones, all accepted ones play in order.
- flush mid-pulse with 2 queued → next cycle active=0, level=0, no done. A length-0 command plays nothing.
- rst_n asserted mid-pulse → all outputs 0 asynchronously, cmd_ready=1 after release.
